// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-aware round-robin arbiter for the async FIFO write port
// Optional macro: FIFO_WR_ARB_PKT_CNT_EN adds o_pkt_cnt / o_beat_cnt counters.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int LOGIC_SIZE = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*LOGIC_SIZE-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_last,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_wr,
    output logic [LOGIC_SIZE-1:0]         o_wdata,
    input  logic                          i_wfull,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy
`ifdef FIFO_WR_ARB_PKT_CNT_EN
    ,
    output logic [15:0]                   o_pkt_cnt,
    output logic [15:0]                   o_beat_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [IDX_W-1:0]    gidx, gidx_nxt;
    logic [NUM_REQ-1:0]  grant_nxt;
    logic                found;
    logic [IDX_W-1:0]    sel_idx;
    int unsigned         cand;
    logic [IDX_W-1:0]    cidx;
    logic                xfer;
    logic                xfer_last;

    // Round-robin search: first valid requester starting at the pointer, wrapping.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = 0;
        cidx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cidx = cand[IDX_W-1:0];
            if (!found && i_req_valid[cidx]) begin
                found   = 1'b1;
                sel_idx = cidx;
            end
        end
    end

    // A beat moves only for the locked requester and only when the FIFO has room.
    assign xfer      = (state == LOCKED) & i_req_valid[gidx] & ~i_wfull;
    assign xfer_last = xfer & i_req_last[gidx];

    // Next-state, grant/pointer update and combinational write-side outputs.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gidx_nxt    = gidx;
        grant_nxt   = o_grant;
        o_req_ready = '0;
        o_wr        = 1'b0;
        o_wdata     = '0;
        o_busy      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt          = LOCKED;
                    gidx_nxt           = sel_idx;
                    grant_nxt          = '0;
                    grant_nxt[sel_idx] = 1'b1;
                end
            end
            LOCKED: begin
                o_busy            = 1'b1;
                o_req_ready[gidx] = ~i_wfull;
                o_wr              = xfer;
                o_wdata           = i_req_data[gidx*LOGIC_SIZE +: LOGIC_SIZE];
                if (xfer_last) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant and pointer registers; reset drops any lock in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gidx    <= '0;
            o_grant <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gidx    <= gidx_nxt;
            o_grant <= grant_nxt;
        end
    end

`ifdef FIFO_WR_ARB_PKT_CNT_EN
    // Packet and beat counters, both free-running and wrapping at 16 bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pkt_cnt  <= '0;
            o_beat_cnt <= '0;
        end else begin
            if (xfer_last) o_pkt_cnt  <= o_pkt_cnt + 16'd1;
            if (xfer)      o_beat_cnt <= o_beat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           i_clk = 1'b0;
    logic           i_rst_n = 1'b1;
    logic [N-1:0]   i_req_valid;
    logic [N*W-1:0] i_req_data;
    logic [N-1:0]   i_req_last;
    logic [N-1:0]   o_req_ready;
    logic           o_wr;
    logic [W-1:0]   o_wdata;
    logic           i_wfull;
    logic [N-1:0]   o_grant;
    logic           o_busy;
`ifdef FIFO_WR_ARB_PKT_CNT_EN
    logic [15:0]    o_pkt_cnt;
    logic [15:0]    o_beat_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fifo_wr_arbiter #(.NUM_REQ(N), .LOGIC_SIZE(W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_wr        (o_wr),
        .o_wdata     (o_wdata),
        .i_wfull     (i_wfull),
        .o_grant     (o_grant),
        .o_busy      (o_busy)
`ifdef FIFO_WR_ARB_PKT_CNT_EN
        ,
        .o_pkt_cnt   (o_pkt_cnt),
        .o_beat_cnt  (o_beat_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge i_clk);
    endtask

    task automatic set_slot(input int k, input logic [W-1:0] val);
        i_req_data[k*W +: W] = val;
    endtask

    int           beat [N];
    logic [W-1:0] wq[$];
    int           g;

`ifdef FIFO_WR_ARB_PKT_CNT_EN
    task automatic send_pkt(input int len);
        i_req_valid[0] = 1'b1;
        i_req_last[0]  = 1'b0;
        step();
        for (int b = 0; b < len; b++) begin
            set_slot(0, W'(b));
            i_req_last[0] = (b == len - 1);
            step();
        end
        i_req_valid = '0;
        i_req_last  = '0;
    endtask
`endif

    initial begin
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;
        i_wfull     = 1'b0;

        // reset held with every requester valid
        #1;
        i_rst_n     = 1'b0;
        i_req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("rst_wr",    32'(o_wr),        32'h0);
            check("rst_grant", 32'(o_grant),     32'h0);
            check("rst_ready", 32'(o_req_ready), 32'h0);
            check("rst_busy",  32'(o_busy),      32'h0);
        end
        step();
        i_rst_n     = 1'b1;
        i_req_valid = '0;

        // single requester, 3-beat packet
        i_req_valid = 4'b0010;
        set_slot(1, 8'h11);
        settle();
        check("single_idle_grant", 32'(o_grant), 32'h0);
        check("single_idle_wr",    32'(o_wr),    32'h0);
        step();
        settle();
        check("single_grant", 32'(o_grant),     32'h2);
        check("single_ready", 32'(o_req_ready), 32'h2);
        check("single_wr0",   32'(o_wr),        32'h1);
        check("single_d0",    32'(o_wdata),     32'h11);
        step();
        set_slot(1, 8'h22);
        settle();
        check("single_wr1", 32'(o_wr),    32'h1);
        check("single_d1",  32'(o_wdata), 32'h22);
        step();
        set_slot(1, 8'h33);
        i_req_last[1] = 1'b1;
        settle();
        check("single_wr2", 32'(o_wr),    32'h1);
        check("single_d2",  32'(o_wdata), 32'h33);
        step();
        i_req_valid = '0;
        i_req_last  = '0;
        settle();
        check("single_end_grant", 32'(o_grant), 32'h0);
        check("single_end_busy",  32'(o_busy),  32'h0);
        check("single_end_wr",    32'(o_wr),    32'h0);
        step();

        // round-robin, all four sending 2-beat packets, pointer reset to 0
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        for (int k = 0; k < N; k++) beat[k] = 0;
        for (int p = 0; p < 5; p++) begin
            g = p % N;
            i_req_valid = '1;
            for (int k = 0; k < N; k++) begin
                set_slot(k, W'(8'h10 * k + beat[k]));
                i_req_last[k] = (beat[k] == 1);
            end
            settle();
            check("rr_idle_grant", 32'(o_grant), 32'h0);
            check("rr_idle_wr",    32'(o_wr),    32'h0);
            step();
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    set_slot(k, W'(8'h10 * k + beat[k]));
                    i_req_last[k] = (beat[k] == 1);
                end
                settle();
                check("rr_grant", 32'(o_grant), 32'(1 << g));
                check("rr_wr",    32'(o_wr),    32'h1);
                check("rr_data",  32'(o_wdata), 32'(8'h10 * g + b));
                beat[g] = beat[g] ^ 1;
                step();
            end
        end
        i_req_valid = '0;
        i_req_last  = '0;
        settle();
        check("rr_end_grant", 32'(o_grant), 32'h0);
        step();

        // backpressure in the middle of a 4-beat packet from req2
        i_req_valid = 4'b0100;
        beat[2] = 0;
        set_slot(2, 8'hA0);
        settle();
        check("bp_idle_grant", 32'(o_grant), 32'h0);
        step();
        for (int c = 0; c < 9; c++) begin
            i_wfull = (c >= 2 && c < 7);
            set_slot(2, W'(8'hA0 + beat[2]));
            i_req_last[2] = (beat[2] == 3);
            settle();
            check("bp_grant", 32'(o_grant),     32'h4);
            check("bp_wr",    32'(o_wr),        32'(!i_wfull));
            check("bp_ready", 32'(o_req_ready), i_wfull ? 32'h0 : 32'h4);
            if (o_wr) wq.push_back(o_wdata);
            if (!i_wfull) beat[2]++;
            step();
        end
        i_wfull     = 1'b0;
        i_req_valid = '0;
        i_req_last  = '0;
        check("bp_count", 32'(wq.size()), 32'd4);
        for (int i = 0; i < wq.size(); i++) check("bp_order", 32'(wq[i]), 32'(8'hA0 + i));
        settle();
        check("bp_end_grant", 32'(o_grant), 32'h0);
        step();

        // reset mid-packet from req3, then req0 wins
        i_req_valid = 4'b1000;
        set_slot(3, 8'h30);
        settle();
        check("mid_idle_grant", 32'(o_grant), 32'h0);
        step();
        for (int b = 0; b < 2; b++) begin
            set_slot(3, W'(8'h30 + b));
            settle();
            check("mid_grant", 32'(o_grant), 32'h8);
            check("mid_data",  32'(o_wdata), 32'(8'h30 + b));
            step();
        end
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_grant", 32'(o_grant), 32'h0);
        check("mid_rst_busy",  32'(o_busy),  32'h0);
        check("mid_rst_wr",    32'(o_wr),    32'h0);
        step();
        step();
        i_rst_n     = 1'b1;
        i_req_valid = 4'b1001;
        set_slot(0, 8'h01);
        i_req_last[0] = 1'b1;
        settle();
        check("post_idle_grant", 32'(o_grant), 32'h0);
        step();
        settle();
        check("post_grant", 32'(o_grant), 32'h1);
        check("post_wr",    32'(o_wr),    32'h1);
        check("post_data",  32'(o_wdata), 32'h01);
        step();
        i_req_valid = '0;
        i_req_last  = '0;
        step();

`ifdef FIFO_WR_ARB_PKT_CNT_EN
        i_rst_n = 1'b0;
        #1;
        check("cnt_rst_pkt",  32'(o_pkt_cnt),  32'h0);
        check("cnt_rst_beat", 32'(o_beat_cnt), 32'h0);
        step();
        i_rst_n = 1'b1;
        send_pkt(3);
        send_pkt(3);
        send_pkt(2);
        send_pkt(2);
        send_pkt(2);
        settle();
        check("cnt_pkt5",   32'(o_pkt_cnt),  32'd5);
        check("cnt_beat12", 32'(o_beat_cnt), 32'd12);
        step();
        send_pkt(65523);
        settle();
        check("cnt_beat_max", 32'(o_beat_cnt), 32'hFFFF);
        step();
        send_pkt(1);
        settle();
        check("cnt_beat_wrap", 32'(o_beat_cnt), 32'h0);
        check("cnt_pkt7",      32'(o_pkt_cnt),  32'd7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Packet-aware round-robin arbiter that shares the single write port of the async FIFO between NUM_REQ requesters in the FIFO write clock domain. It grants one requester at a time and holds the grant until that requester's last beat. Winning beats are forwarded to the FIFO write interface, with FIFO full backpressure applied. It sits directly upstream of the async FIFO in the serializer path.

Parameters:
NUM_REQ, 4, number of requester channels (2..16)
LOGIC_SIZE, 8, data word width in bits; matches the FIFO LOGIC_SIZE

Ports:
i_clk  input  1  write-domain clock; same net as the FIFO write clock
i_rst_n  input  1  asynchronous active-low reset
i_req_valid  input  NUM_REQ  per-requester beat valid
i_req_data  input  NUM_REQ*LOGIC_SIZE  per-requester data; requester k owns bits [k*LOGIC_SIZE +: LOGIC_SIZE]
i_req_last  input  NUM_REQ  per-requester end-of-packet flag, qualified by valid
o_req_ready  output  NUM_REQ  per-requester ready; a beat transfers when valid & ready
o_wr  output  1  FIFO write request
o_wdata  output  LOGIC_SIZE  FIFO write data
i_wfull  input  1  FIFO full flag
o_grant  output  NUM_REQ  one-hot current grant; all zero when idle
o_busy  output  1  high while in LOCKED

Behaviour:
- Interface: one clock (i_clk); reset is asynchronous and active-low (i_rst_n).
- Reset values:
  - state=IDLE, o_grant=0, round-robin pointer=0.
  - o_wr=0, o_req_ready=0, o_busy=0, o_wdata=0.
  - Reset is effective immediately on assertion and released synchronously.
- FSM IDLE:
  - o_req_ready=0, o_wr=0.
  - If any i_req_valid is set, select the first valid index searching pointer, pointer+1, ... modulo NUM_REQ.
  - Register the one-hot grant and go to LOCKED.
  - Arbitration latency is 1 cycle: valid seen at cycle N, first beat may transfer at N+1.
- FSM LOCKED (grant index g):
  - o_busy=1.
  - o_req_ready[g] = ~i_wfull; all other ready bits are 0.
  - o_wr = i_req_valid[g] & ~i_wfull (combinational).
  - o_wdata = data slice g (combinational, valid whenever o_wr=1).
  - Transfer = i_req_valid[g] & ~i_wfull.
  - On a transfer with i_req_last[g]=1: pointer <= (g+1) mod NUM_REQ, o_grant <= 0, next state IDLE.
  - Valid deasserting mid-packet: the grant is held and no write occurs.
- Full boundary: while i_wfull=1, o_wr=0 and ready=0; the grant is kept, no beat is lost or duplicated.
- Single-beat packet (valid & last on the first granted cycle): 1 write, then back to IDLE.
- Fairness: between any two grants to requester k, every other continuously requesting channel receives exactly one grant.
- Pointer wrap: g=NUM_REQ-1 wraps the pointer to 0.
- Reset mid-packet: the lock is dropped, the partial packet is abandoned, the pointer returns to 0.
- Requester inputs must stay stable while valid & ~ready (AXIS rule); the arbiter does not check this.

Optional Feature:
Macro FIFO_WR_ARB_PKT_CNT_EN.
- Defined:
  - Adds output o_pkt_cnt [15:0], reset 0.
  - Increments by 1 on every transfer with last=1, wrapping 0xFFFF to 0.
  - Adds output o_beat_cnt [15:0], reset 0, incremented on every o_wr, wrapping.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset: hold i_rst_n=0 with all valids high -> o_wr=0, o_grant=0, o_req_ready=0, o_busy=0 throughout.
- Single requester: req1 sends 3 beats 0x11,0x22,0x33 (last on 0x33), i_wfull=0 -> o_grant=4'b0010 one cycle after valid; o_wr pulses for 3 consecutive cycles with data 0x11,0x22,0x33; IDLE on the next cycle.
- Round-robin: all 4 requesters continuously send 2-beat packets -> grant order 0,1,2,3,0; each packet is 2 writes, followed by 1 idle cycle; beats are never interleaved.
- Backpressure: i_wfull=1 for 5 cycles in the middle of a 4-beat packet from req2 -> o_wr=0 and o_req_ready[2]=0 during those cycles; all 4 beats are written in order exactly once; o_grant stays 4'b0100.
- Reset mid-packet: assert reset after beat 2 of a 4-beat packet from req3 -> o_grant=0 immediately; after release, req0 and req3 both valid -> req0 is granted first (pointer=0).
- With FIFO_WR_ARB_PKT_CNT_EN: 5 packets totalling 12 beats -> o_pkt_cnt=5, o_beat_cnt=12; starting o_beat_cnt from 0xFFFF, one beat wraps it to 0.
